// File: rtl/cmd_read_vertex.sv
// Vertex read-back responder: reads count vertices from the vertex RAM and streams
// them as a framed packet (SYNC, LEN, opcode, COUNT, START, payload, XOR CRC).
module cmd_read_vertex #(
   parameter int DEPTH = 1024,
   parameter int DW    = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          rst,
   input  logic          req_pulse,
   input  logic [15:0]   req_start,
   input  logic [7:0]    req_count,
   output logic [AW-1:0] vertex_raddr,
   output logic          vertex_re,
   input  logic [DW-1:0] vertex_rdata,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          BUSY,
   output logic          done_pulse,
   output logic          err_count,
   output logic          err_range,
   output logic [2:0]    state_dbg
);

   // tx handshake: a byte moves on a cycle with tx_valid && tx_ready; while
   // tx_valid is high and tx_ready low, tx_data and tx_valid are held.
   typedef enum logic [2:0] {IDLE, HDR, RD, CAP, PAY, CRC, FIN} state_t;

   state_t      state_q, state_d;
   logic        pend_q, pend_d;
   logic [15:0] start_q, start_d;
   logic [7:0]  count_q, count_d;
   logic [2:0]  byte_q, byte_d;
   logic [4:0]  vtx_q, vtx_d;
   logic [63:0] sh_q, sh_d;
   logic [7:0]  crc_q, crc_d;
   logic        err_count_q, err_count_d;
   logic        err_range_q, err_range_d;

   logic [16:0] end_addr;
   logic [7:0]  len_byte;
   logic        xfer;

   assign end_addr  = {1'b0, req_start} + {9'b0, req_count};
   assign len_byte  = 8'd5 + {count_q[4:0], 3'b000};
   assign tx_valid  = (state_q == HDR) || (state_q == PAY) || (state_q == CRC);
   assign xfer      = tx_valid && tx_ready;
   // pend_q covers the validation cycle between acceptance and the first header byte
   assign BUSY      = pend_q || tx_valid || (state_q == RD) || (state_q == CAP);
   assign err_count = err_count_q;
   assign err_range = err_range_q;
   assign state_dbg = state_q;

   always_comb begin
      tx_data = 8'h00;
      case (state_q)
         HDR: begin
            case (byte_q)
               3'd0:    tx_data = 8'hAA;
               3'd1:    tx_data = len_byte;
               3'd2:    tx_data = 8'h04;
               3'd3:    tx_data = count_q;
               3'd4:    tx_data = start_q[15:8];
               3'd5:    tx_data = start_q[7:0];
               default: tx_data = 8'h00;
            endcase
         end
         PAY:     tx_data = sh_q[63:56];
         CRC:     tx_data = crc_q;
         default: tx_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      start_d      = start_q;
      count_d      = count_q;
      byte_d       = byte_q;
      vtx_d        = vtx_q;
      sh_d         = sh_q;
      crc_d        = crc_q;
      err_count_d  = err_count_q;
      err_range_d  = err_range_q;
      vertex_re    = 1'b0;
      vertex_raddr = '0;
      done_pulse   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q) begin
               pend_d = 1'b0;
               byte_d = 3'd0;
               if (!err_count_q && !err_range_q) state_d = HDR;
            end else if (req_pulse) begin
               pend_d      = 1'b1;
               start_d     = req_start;
               count_d     = req_count;
               vtx_d       = 5'd0;
               crc_d       = 8'h00;
               err_count_d = (req_count == 8'd0) || (req_count > 8'd31);
               err_range_d = end_addr > 17'(DEPTH);
            end
         end
         HDR: begin
            if (xfer) begin
               if (byte_q != 3'd0) crc_d = crc_q ^ tx_data;
               if (byte_q == 3'd5) begin
                  byte_d  = 3'd0;
                  state_d = RD;
               end else begin
                  byte_d = byte_q + 3'd1;
               end
            end
         end
         RD: begin
            vertex_re    = 1'b1;
            vertex_raddr = start_q[AW-1:0] + AW'(vtx_q);
            state_d      = CAP;
         end
         CAP: begin
            sh_d    = vertex_rdata[63:0];
            state_d = PAY;
         end
         PAY: begin
            if (xfer) begin
               crc_d = crc_q ^ tx_data;
               sh_d  = {sh_q[55:0], 8'h00};
               if (byte_q == 3'd7) begin
                  byte_d = 3'd0;
                  if ({3'b000, vtx_q} == count_q - 8'd1) begin
                     state_d = CRC;
                  end else begin
                     vtx_d   = vtx_q + 5'd1;
                     state_d = RD;
                  end
               end else begin
                  byte_d = byte_q + 3'd1;
               end
            end
         end
         CRC: begin
            if (xfer) state_d = FIN;
         end
         FIN: begin
            done_pulse = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q     <= IDLE;
         pend_q      <= 1'b0;
         start_q     <= 16'h0;
         count_q     <= 8'h0;
         byte_q      <= 3'd0;
         vtx_q       <= 5'd0;
         sh_q        <= 64'h0;
         crc_q       <= 8'h0;
         err_count_q <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         start_q     <= start_d;
         count_q     <= count_d;
         byte_q      <= byte_d;
         vtx_q       <= vtx_d;
         sh_q        <= sh_d;
         crc_q       <= crc_d;
         err_count_q <= err_count_d;
         err_range_q <= err_range_d;
      end
   end

endmodule

// File: tb/tb_cmd_read_vertex.sv
// Directed bench for cmd_read_vertex: a RAM model feeds the DUT and a byte
// scoreboard checks every transferred response byte against a packet model.
module tb_cmd_read_vertex;

   logic        CLK = 1'b0;
   logic        rst = 1'b1;
   logic        req_pulse = 1'b0;
   logic [15:0] req_start = 16'h0;
   logic [7:0]  req_count = 8'h0;
   logic [9:0]  vertex_raddr;
   logic        vertex_re;
   logic [63:0] vertex_rdata = 64'h0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        BUSY;
   logic        done_pulse;
   logic        err_count;
   logic        err_range;
   logic [2:0]  state_dbg;

   cmd_read_vertex #(.DEPTH(1024), .DW(64)) dut (
      .CLK(CLK), .rst(rst), .req_pulse(req_pulse), .req_start(req_start),
      .req_count(req_count), .vertex_raddr(vertex_raddr), .vertex_re(vertex_re),
      .vertex_rdata(vertex_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .BUSY(BUSY), .done_pulse(done_pulse),
      .err_count(err_count), .err_range(err_range), .state_dbg(state_dbg)
   );

   always #5 CLK = ~CLK;

   logic [63:0] ram [1024];
   logic [7:0]  exp_q [$];
   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          cyc_g = 0;
   int          ready_mode = 0;
   int          stall_at = 0;
   bit          no_tx = 1'b0;
   bit          hold_v = 1'b0;
   logic [7:0]  hold_d = 8'h0;
   int          cur_start = 0;
   int          vre_i = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // registered-read RAM model
   always @(posedge CLK) if (vertex_re) vertex_rdata <= ram[vertex_raddr];

   // sink readiness patterns: 0 always ready, 1 toggle with a 5-cycle stall, 2 random
   initial begin
      forever begin
         @(posedge CLK); #1;
         cyc_g++;
         case (ready_mode)
            1:       tx_ready = (cyc_g >= stall_at && cyc_g < stall_at + 5) ? 1'b0 : cyc_g[0];
            2:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b1;
         endcase
      end
   end

   // output monitor: scoreboard pops, stall stability, read address, quiet periods
   always @(negedge CLK) begin
      if (hold_v) begin
         chk("stall_valid", 32'(tx_valid), 32'd1);
         chk("stall_data", 32'(tx_data), 32'(hold_d));
      end
      hold_v = 1'b0;
      if (tx_valid === 1'b1) begin
         if (tx_ready) begin
            chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
         end else begin
            hold_v = 1'b1;
            hold_d = tx_data;
         end
      end
      if (vertex_re === 1'b1) begin
         chk("raddr", 32'(vertex_raddr), 32'((cur_start + vre_i) % 1024));
         vre_i++;
      end
      if (no_tx) begin
         chk("quiet_tx_valid", 32'(tx_valid), 32'd0);
         chk("quiet_vertex_re", 32'(vertex_re), 32'd0);
         chk("quiet_done", 32'(done_pulse), 32'd0);
      end
      if (done_pulse === 1'b1) done_cnt++;
   end

   task automatic push_pkt(input int st, input int cnt);
      logic [7:0]  crc, b;
      logic [63:0] w;
      exp_q.push_back(8'hAA);
      b = 8'(5 + 8 * cnt);       exp_q.push_back(b); crc = b;
      b = 8'h04;                 exp_q.push_back(b); crc ^= b;
      b = 8'(cnt);               exp_q.push_back(b); crc ^= b;
      b = 8'(st >> 8);           exp_q.push_back(b); crc ^= b;
      b = 8'(st);                exp_q.push_back(b); crc ^= b;
      for (int v = 0; v < cnt; v++) begin
         w = ram[st + v];
         for (int j = 7; j >= 0; j--) begin
            b = w[8*j +: 8];
            exp_q.push_back(b);
            crc ^= b;
         end
      end
      exp_q.push_back(crc);
   endtask

   // One request; inj_k injects a foreign req_pulse, rst_k asserts reset at that cycle.
   task automatic run_req(input int st, input int cnt, input int mode,
                          input int inj_k, input int rst_k);
      bit ec, er, ok;
      int first_v, done_k, done0;
      ec = (cnt == 0) || (cnt > 31);
      er = (st + cnt) > 1024;
      ok = !ec && !er;
      first_v = -1;
      done_k = -1;
      done0 = done_cnt;
      @(negedge CLK);
      ready_mode = mode;
      stall_at = cyc_g + 30;
      cur_start = st;
      vre_i = 0;
      if (ok) push_pkt(st, cnt);
      req_start = 16'(st);
      req_count = 8'(cnt);
      req_pulse = 1'b1;
      for (int k = 1; k <= 800; k++) begin
         @(negedge CLK);
         req_pulse = (k == inj_k);
         if (k == inj_k) begin
            req_start = 16'h0005;
            req_count = 8'd3;
         end
         if (k == 1) begin
            chk("busy_rise", 32'(BUSY), 32'd1);
            chk("err_count", 32'(err_count), 32'(ec));
            chk("err_range", 32'(err_range), 32'(er));
            if (!ok) no_tx = 1'b1;
         end
         if (!ok) begin
            if (k == 2) chk("err_busy_fall", 32'(BUSY), 32'd0);
            if (k == 5) begin
               chk("err_sticky", 32'({err_count, err_range}), 32'({ec, er}));
               break;
            end
         end else begin
            if (k == rst_k) rst = 1'b1;
            if (rst_k > 0 && k == rst_k + 1) begin
               chk("rst_tx_valid", 32'(tx_valid), 32'd0);
               chk("rst_busy", 32'(BUSY), 32'd0);
               rst = 1'b0;
               exp_q.delete();
               no_tx = 1'b1;
            end
            if (rst_k > 0 && k == rst_k + 6) begin
               chk("rst_no_done", 32'(done_cnt - done0), 32'd0);
               break;
            end
            if (tx_valid === 1'b1 && first_v < 0) first_v = k;
            if (done_pulse === 1'b1 && rst_k <= 0) begin
               done_k = k;
               chk("fin_busy", 32'(BUSY), 32'd0);
               break;
            end
         end
      end
      no_tx = 1'b0;
      if (ok && rst_k <= 0) begin
         chk("done_seen", 32'(done_k > 0), 32'd1);
         chk("queue_drained", 32'(exp_q.size()), 32'd0);
         if (mode == 0) begin
            chk("first_byte_cycle", 32'(first_v), 32'd2);
            chk("done_cycle", 32'(done_k), 32'(9 + 10 * cnt));
         end
         chk("vertex_reads", 32'(vre_i), 32'(cnt));
         @(negedge CLK);
         chk("done_single", 32'(done_cnt - done0), 32'd1);
      end
      exp_q.delete();
      ready_mode = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = {$urandom(), $urandom()};
      ram[16'h10] = 64'h006400C80000E310;
      ram[16'h11] = 64'h0032009600004F20;
      rst = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_raddr", 32'(vertex_raddr), 32'd0);
      chk("rst_re", 32'(vertex_re), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(done_pulse), 32'd0);
      chk("rst_errs", 32'({err_count, err_range}), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      rst = 1'b0;
      @(negedge CLK);

      run_req(16'h10, 2, 0, -1, -1);     // reference packet, ready always high
      run_req(16'h10, 2, 1, -1, -1);     // toggling ready plus stall
      run_req(1020, 5, 0, -1, -1);       // range error
      run_req(0, 0, 0, -1, -1);          // count zero
      run_req(0, 32, 0, -1, -1);         // count too large
      run_req(1000, 40, 0, -1, -1);      // both errors
      run_req(1023, 1, 0, -1, -1);       // last address
      run_req(16'h10, 2, 0, 15, -1);     // request during payload ignored
      run_req(16'h10, 2, 0, -1, 15);     // reset during payload
      run_req(16'h100, 3, 2, -1, -1);    // recovery with random ready
      run_req(5, 31, 0, -1, -1);         // maximum count

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmd_read_vertex.md
CMD_READ_VERTEX -- requirements
Module: cmd_read_vertex

Interface
REQ-001 The block SHALL take these parameters:
- DEPTH, default 1024, vertex RAM entries.
- DW, default 64, vertex word width.
- AW = $clog2(DEPTH), derived.

REQ-002 The block SHALL have these ports:
- CLK  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_pulse  in  1  one-cycle read-back request.
- req_start  in  16  first vertex address.
- req_count  in  8  number of vertices.
- vertex_raddr  out  AW  vertex RAM read address.
- vertex_re  out  1  vertex RAM read enable; data returns on vertex_rdata one cycle later.
- vertex_rdata  in  DW  {x[63:48], y[47:32], z[31:16], RGB332[15:8], reserve[7:4], uv[3:0]}.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- BUSY  out  1  request in progress.
- done_pulse  out  1  one cycle high after the CRC byte transfers.
- err_count  out  1  sticky, count invalid.
- err_range  out  1  sticky, address range invalid.

Function
REQ-003 The response packet SHALL be emitted in this order:
- 0xAA.
- LEN = 5 + 8*count.
- Opcode 0x04.
- COUNT.
- START[15:8], START[7:0].
- count x 8 payload bytes.
- CRC.

REQ-004 Each vertex SHALL be serialized big-endian: x_hi, x_lo, y_hi, y_lo, z_hi, z_lo, RGB, {reserve,uv}, i.e. vertex_rdata[63:56] first and [7:0] last.

REQ-005 CRC SHALL be the 8-bit XOR of every transferred byte from LEN through the last payload byte. SYNC and CRC are excluded.

REQ-006 A byte SHALL transfer only in a cycle where tx_valid && tx_ready. While tx_valid=1 && tx_ready=0, tx_data SHALL hold stable and tx_valid SHALL stay high.

REQ-007 req_pulse SHALL be accepted only when BUSY=0; req_pulse while BUSY=1 SHALL be ignored without side effects.

REQ-008 On acceptance the block SHALL:
- latch start/count;
- clear err_count and err_range;
- set BUSY=1 on the next cycle.

REQ-009 Validation SHALL happen in the acceptance cycle:
- count==0 or count>31 sets err_count.
- start+count > DEPTH, computed 17-bit without truncation, sets err_range.
- Both flags may set together.
- On any error: no byte is emitted, vertex_re is never asserted, BUSY returns to 0 one cycle after it rose, and done_pulse is not asserted.

REQ-010 The state machine SHALL have states IDLE, HDR, RD, CAP, PAY, CRC, FIN:
- IDLE -> HDR: valid request.
- HDR -> RD: 6 header bytes transferred.
- RD: asserts vertex_re=1 for exactly one cycle with vertex_raddr=start+i, then -> CAP.
- CAP: latches vertex_rdata into a 64-bit shift register, then -> PAY.
- PAY -> RD: 8 bytes sent and i<count-1; i increments.
- PAY -> CRC: 8 bytes sent and i==count-1.
- CRC -> FIN: CRC byte transferred.
- FIN: done_pulse=1, BUSY=0 -> IDLE.

REQ-011 tx_valid SHALL be 1 only in HDR, PAY and CRC; it SHALL be 0 in RD and CAP, giving a 2-cycle gap between vertices.

REQ-012 With tx_ready held at 1, the first byte 0xAA SHALL appear with tx_valid=1 in the cycle after BUSY rises. Total active cycles = 6 + count*10 + 1, plus 1 for FIN.

REQ-013 vertex_raddr SHALL be the low AW bits of start+i; no wrap occurs because REQ-009 guarantees range.

REQ-014 A new request SHALL be accepted in the cycle after FIN, i.e. once BUSY=0.

Reset
REQ-015 In the cycle after rst=1, all outputs SHALL be 0: vertex_raddr, vertex_re, tx_data, tx_valid, BUSY, done_pulse, err_count, err_range. State SHALL be IDLE, and the counters and CRC accumulator SHALL be 0.

REQ-016 rst asserted mid-packet SHALL abort immediately: tx_valid=0 on the next edge, no further bytes, and no done_pulse.

REQ-017 rst SHALL take priority over req_pulse in the same cycle.

Verification
REQ-018 start=0x0010, count=2, RAM[0x10]=0x006400C80000E310, RAM[0x11]=0x0032009600004F20, tx_ready=1 -> bytes AA 15 04 02 00 10 00 64 00 C8 00 00 E3 10 00 32 00 96 00 00 4F 20 CRC=XOR(15..20), then done_pulse.

REQ-019 Same stimulus with tx_ready toggling 1/0 every cycle plus a 5-cycle low stall mid-payload -> identical byte sequence, tx_data stable during stalls, no duplicated or dropped bytes.

REQ-020 Range and count errors:
- start=1020, count=5, DEPTH=1024 -> err_range=1, no tx_valid, vertex_re never high, BUSY low after 2 cycles.
- count=0 -> err_count=1.
- count=32 -> err_count=1.

REQ-021 start=1023, count=1 -> accepted; vertex_raddr=1023; LEN=0x0D; 15 bytes total.

REQ-022 Mid-packet interference:
- req_pulse during payload -> ignored; the packet completes unchanged.
- rst during payload -> tx_valid=0 next cycle, BUSY=0, no done_pulse; a subsequent request then completes correctly.
